// File: rtl/cla_seq_add_ctrl.sv
//==============================================================================
// Module   : cla_seq_add_ctrl (with leaf carry_look_ahead_adder_4bit)
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor built around one shared
//            4-bit carry-look-ahead slice. Operands are captured on a
//            valid/ready handshake and processed one nibble per clock, LSB
//            nibble first, with the carry rippling through a register.
//            The result is offered on a second valid/ready handshake.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active high
//            in_valid   - operand set present
//            in_ready   - controller idle and able to accept operands
//            a, b       - WIDTH-bit operands
//            cin        - carry-in (add) / borrow-in (sub)
//            sub        - 0: a+b+cin, 1: a-b-cin
//            out_valid  - result present
//            out_ready  - consumer accepts result
//            sum        - WIDTH-bit result
//            cout       - carry-out (add) / not-borrow (sub)
//            ovf        - signed two's-complement overflow
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

// 4-bit carry-look-ahead slice: all internal carries are produced directly
// from generate/propagate terms rather than rippling bit to bit.
module carry_look_ahead_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[3:0];
  assign cout = w_c[4];

endmodule

module cla_seq_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Captured operands. Subtraction is folded in at capture time: b is stored
  // inverted and the carry register seeded with ~cin, so every pass is a
  // plain add (a - b - cin == a + ~b + ~cin).
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  // Nibble currently being processed; counter value k selects bits [4k+3:4k].
  assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4];

  carry_look_ahead_adder_4bit u_cla (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);

  //----------------------------------------------------------------------------
  // Control FSM
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == C_LAST) begin
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Datapath
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum[{r_cnt, 2'b00} +: 4] <= w_s;
      r_carry                    <= w_co;
      if (w_last) begin
        // Final pass: the slice's top bit is the word MSB, so carry-into-MSB
        // is recovered as a^b'^s of that bit and xored with the carry-out.
        r_cout <= w_co;
        r_ovf  <= w_a_nib[3] ^ w_b_nib[3] ^ w_s[3] ^ w_co;
      end else begin
        // Counter holds at the last nibble index until the next accept.
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire
